// File: rtl/apb_master_cmd.sv
// Command-stream to APB3 master: one transfer at a time, PREADY wait states, PSLVERR/misalignment reporting.
// Optional ACCESS timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master_cmd: TIMEOUT_CYCLES must be within 1..255");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWDATA    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            // Misaligned commands never touch the bus; answer with an error straight away.
            if (cmd_addr[1:0] != 2'b00) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else begin
              PADDR  <= cmd_addr;
              PWRITE <= cmd_write;
              PWDATA <= cmd_wdata;
              PSEL   <= 1'b1;
              state  <= SETUP;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            state     <= RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          // This is the TIMEOUT_CYCLES-th low cycle: abort; a simultaneous PREADY wins above.
          else if (wait_cnt == TIMEOUT_LAST) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule
